// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press, release and repeat events,
// with a long-press level; hold timing is counted in timebase ticks.
module button_event_gen #(
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic long_press,
    output logic held
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_REPEAT  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             prev_level_r;
    logic             press_pulse_r;
    logic             release_pulse_r;
    logic             repeat_pulse_r;
    logic             long_press_r;
    logic             held_r;

    logic             rise_s;
    logic             hold_hit_s;
    logic             repeat_hit_s;

    // Edge detect and tick-count compare matches for the current cycle.
    always_comb begin
        rise_s       = level & ~prev_level_r;
        hold_hit_s   = tick & (cnt_r == HOLD_LAST);
        repeat_hit_s = tick & (cnt_r == REPEAT_LAST);
    end

    // Event FSM; prev_level resets high so a button held through reset is not a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            cnt_r           <= CNT_ZERO;
            prev_level_r    <= 1'b1;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
            repeat_pulse_r  <= 1'b0;
            long_press_r    <= 1'b0;
            held_r          <= 1'b0;
        end else begin
            prev_level_r    <= level;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
            repeat_pulse_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r        <= CNT_ZERO;
                    long_press_r <= 1'b0;
                    if (rise_s) begin
                        state_r       <= ST_PRESSED;
                        press_pulse_r <= 1'b1;
                        held_r        <= 1'b1;
                    end else begin
                        held_r        <= 1'b0;
                    end
                end
                ST_PRESSED: begin
                    // Release wins over a coincident tick.
                    if (!level) begin
                        state_r         <= ST_IDLE;
                        cnt_r           <= CNT_ZERO;
                        release_pulse_r <= 1'b1;
                        long_press_r    <= 1'b0;
                        held_r          <= 1'b0;
                    end else if (hold_hit_s) begin
                        state_r        <= ST_REPEAT;
                        cnt_r          <= CNT_ZERO;
                        long_press_r   <= 1'b1;
                        repeat_pulse_r <= 1'b1;
                        held_r         <= 1'b1;
                    end else if (tick) begin
                        cnt_r  <= cnt_r + CNT_ONE;
                        held_r <= 1'b1;
                    end else begin
                        held_r <= 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!level) begin
                        state_r         <= ST_IDLE;
                        cnt_r           <= CNT_ZERO;
                        release_pulse_r <= 1'b1;
                        long_press_r    <= 1'b0;
                        held_r          <= 1'b0;
                    end else if (repeat_hit_s) begin
                        cnt_r          <= CNT_ZERO;
                        repeat_pulse_r <= 1'b1;
                        long_press_r   <= 1'b1;
                        held_r         <= 1'b1;
                    end else if (tick) begin
                        cnt_r        <= cnt_r + CNT_ONE;
                        long_press_r <= 1'b1;
                        held_r       <= 1'b1;
                    end else begin
                        long_press_r <= 1'b1;
                        held_r       <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= CNT_ZERO;
                    long_press_r <= 1'b0;
                    held_r       <= 1'b0;
                end
            endcase
        end
    end

    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;
    assign repeat_pulse  = repeat_pulse_r;
    assign long_press    = long_press_r;
    assign held          = held_r;

endmodule
